dmem_arbiter: RTL and testbench

- Two-port round-robin arbiter and access sequencer in front of the single-port data memory.
- Requester 0 is the core load/store path; requester 1 is the debug/loader port used for memory preload and inspection.
- Converts request/acknowledge handshakes into the memory's address, writeData, memWrite and memRead strobes.
- Registers read data and returns it with a one-cycle acknowledge; flags misaligned and out-of-range accesses.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter_rr_arb2.sv | 14 +
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;
  localparam int DMEM_DEPTH = 32;
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Request captured at grant; requesters may change inputs afterwards.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Misaligned byte address or word index beyond the memory.
  function automatic logic addr_err(input logic [31:0] a, input logic [31:0] depth);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes plus the single-port memory bus.
interface dmem_arbiter_if;
  logic        req0, we0, ack0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, we1, ack1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [31:0] mem_address, mem_writeData, mem_ReadData;
  logic        mem_memWrite, mem_memRead;

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_ReadData,
    output ack0, err0, rdata0, ack1, err1, rdata1,
           mem_address, mem_writeData, mem_memWrite, mem_memRead
  );

  // Requesters and memory side.
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_ReadData,
    input  ack0, err0, rdata0, ack1, err1, rdata1,
           mem_address, mem_writeData, mem_memWrite, mem_memRead
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker; on conflict the port opposite last_grant wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);
  // Single requester wins outright; conflict goes to the other side of last_grant.
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = (req0 & req1) ? ~last_grant : req1;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the data memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output logic           busy
);
  state_t          state;
  logic            last_grant, gid;
  dmem_req_t       lreq, sel_req;
  logic            gnt_valid, gnt_id, lerr, both;
  logic [1:0]      ack_q, err_q;
  logic [1:0][31:0] rdata_q;

  rr_arb2 u_rr (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last_grant(last_grant),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Granted port's request and the check on the latched address.
  always_comb begin
    sel_req = gnt_id ? {bus.we1, bus.addr1, bus.wdata1}
                     : {bus.we0, bus.addr0, bus.wdata0};
    both    = bus.req0 & bus.req1;
    lerr    = addr_err(lreq.addr, 32'(DEPTH));
  end

  // Sequencer: IDLE -> ACCESS -> RESP, one cycle each after grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gid        <= 1'b0;
      lreq       <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_valid) begin
          state <= ACCESS;
          gid   <= gnt_id;
          lreq  <= sel_req;
          if (both) last_grant <= gnt_id;
        end
        ACCESS: begin
          state        <= RESP;
          ack_q[gid]   <= 1'b1;
          err_q[gid]   <= lerr;
          if (!lreq.we) rdata_q[gid] <= lerr ? '0 : bus.mem_ReadData;
        end
        RESP: begin
          state <= IDLE;
          ack_q <= '0;
          err_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from state so reset drops them at once.
  always_comb begin
    bus.mem_address   = '0;
    bus.mem_writeData = '0;
    bus.mem_memWrite  = 1'b0;
    bus.mem_memRead   = 1'b0;
    if (state == ACCESS) begin
      bus.mem_address   = {{(32-AW){1'b0}}, lreq.addr[AW+1:2]};
      bus.mem_writeData = lreq.wdata;
      bus.mem_memWrite  = lreq.we & ~lerr;
      bus.mem_memRead   = ~lreq.we & ~lerr;
    end
  end

  assign busy       = (state != IDLE);
  assign bus.ack0   = ack_q[0];
  assign bus.ack1   = ack_q[1];
  assign bus.err0   = err_q[0];
  assign bus.err1   = err_q[1];
  assign bus.rdata0 = rdata_q[0];
  assign bus.rdata1 = rdata_q[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32-word memory.
module tb_dmem_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic        preload;
  logic [31:0] mem [32];
  int          ncmp = 0;
  int          nerr = 0;

  dmem_arbiter_if bus();

  dmem_arbiter dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clock = ~clock;

  // Single-port memory: combinational read, write on the rising edge.
  assign bus.mem_ReadData = mem[bus.mem_address[4:0]];
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (bus.mem_memWrite) begin
      mem[bus.mem_address[4:0]] <= bus.mem_writeData;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? bus.ack0 : bus.ack1;
  endfunction
  function automatic logic get_err(input int p);
    return (p == 0) ? bus.err0 : bus.err1;
  endfunction
  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? bus.rdata0 : bus.rdata1;
  endfunction

  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  // One isolated transaction: ACCESS in the cycle after issue, ack the cycle after that.
  task automatic run_one(input string tag, input int p, input logic we,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic exp_wr, input logic exp_rd, input logic exp_err,
                         input logic [31:0] exp_idx,
                         input logic chk_rd, input logic [31:0] exp_rdata);
    issue(p, we, a, d);
    tick();
    chk({tag, ".wr"},   32'(bus.mem_memWrite), 32'(exp_wr));
    chk({tag, ".rd"},   32'(bus.mem_memRead),  32'(exp_rd));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    if (exp_wr || exp_rd) chk({tag, ".addr"}, bus.mem_address, exp_idx);
    if (exp_wr) chk({tag, ".wdata"}, bus.mem_writeData, d);
    tick();
    chk({tag, ".ack"},   32'(get_ack(p)), 32'd1);
    chk({tag, ".other"}, 32'(get_ack(1 - p)), 32'd0);
    chk({tag, ".err"},   32'(get_err(p)), 32'(exp_err));
    chk({tag, ".strb"},  32'(bus.mem_memWrite | bus.mem_memRead), 32'd0);
    if (chk_rd) chk({tag, ".rdata"}, get_rdata(p), exp_rdata);
    drop(p);
    tick();
    chk({tag, ".idle"}, 32'(get_ack(p) | busy), 32'd0);
  endtask

  initial begin
    int order[$];
    int exp_order[5];
    int c0, c1;
    bit done;

    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    preload = 1'b1;
    #1 reset = 1'b0;
    tick();
    tick();
    preload = 1'b0;

    // Reset state
    chk("rst.ack",   32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 32'd0);
    chk("rst.rd0",   bus.rdata0, 32'd0);
    chk("rst.rd1",   bus.rdata1, 32'd0);
    chk("rst.strb",  32'({bus.mem_memWrite, bus.mem_memRead, busy}), 32'd0);
    chk("rst.addr",  bus.mem_address, 32'd0);
    chk("rst.wdata", bus.mem_writeData, 32'd0);
    reset = 1'b1;
    tick();

    // Store then load through port 0
    run_one("st8", 0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'd2, 1'b0, 32'd0);
    run_one("ld8", 0, 1'b0, 32'h8, 32'h0,        1'b0, 1'b1, 1'b0, 32'd2, 1'b1, 32'hDEADBEEF);

    // Simultaneous pair: port 0 first, port 1 three cycles later
    issue(0, 1'b0, 32'h0, 32'h0);
    issue(1, 1'b0, 32'h4, 32'h0);
    tick();
    chk("pr1.addr", bus.mem_address, 32'd0);
    tick();
    chk("pr1.ack0",  32'(bus.ack0), 32'd1);
    chk("pr1.ack1",  32'(bus.ack1), 32'd0);
    chk("pr1.rd0",   bus.rdata0, 32'h1000_0000);
    drop(0);
    tick();
    chk("pr1.gap",   32'(bus.ack0 | bus.ack1 | busy), 32'd0);
    tick();
    chk("pr1.addr1", bus.mem_address, 32'd1);
    tick();
    chk("pr1.ack1b", 32'(bus.ack1), 32'd1);
    chk("pr1.rd1",   bus.rdata1, 32'h1000_0001);
    drop(1);
    tick();

    // Second pair: port 1 now has priority
    issue(0, 1'b0, 32'hC, 32'h0);
    issue(1, 1'b0, 32'h10, 32'h0);
    tick();
    chk("pr2.addr1", bus.mem_address, 32'd4);
    tick();
    chk("pr2.ack1",  32'(bus.ack1), 32'd1);
    chk("pr2.ack0",  32'(bus.ack0), 32'd0);
    chk("pr2.rd1",   bus.rdata1, 32'h1000_0004);
    drop(1);
    tick();
    tick();
    chk("pr2.addr0", bus.mem_address, 32'd3);
    tick();
    chk("pr2.ack0b", 32'(bus.ack0), 32'd1);
    chk("pr2.rd0",   bus.rdata0, 32'h1000_0003);
    drop(0);
    tick();

    // Misaligned store on port 1, then word 31 must be untouched
    run_one("mis", 1, 1'b1, 32'h7E, 32'h55, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0);
    run_one("w31", 1, 1'b0, 32'h7C, 32'h0,  1'b0, 1'b1, 1'b0, 32'd31, 1'b1, 32'h1000_001F);

    // Out-of-range load: err, rdata forced to 0
    run_one("oor", 0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd0);

    // Port 0 held for 3 loads while port 1 makes 2
    exp_order = '{0, 1, 0, 1, 0};
    c0 = 0; c1 = 0; done = 0;
    issue(0, 1'b0, 32'h14, 32'h0);
    issue(1, 1'b0, 32'h18, 32'h0);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      tick();
      chk("rr.overlap", 32'(bus.ack0 & bus.ack1), 32'd0);
      if (bus.ack0) begin
        order.push_back(0);
        chk("rr.rd0", bus.rdata0, 32'h1000_0005);
        c0++;
        if (c0 == 3) drop(0);
      end
      if (bus.ack1) begin
        order.push_back(1);
        chk("rr.rd1", bus.rdata1, 32'h1000_0006);
        c1++;
        if (c1 == 2) drop(1);
      end
      if (c0 == 3 && c1 == 2) done = 1;
    end
    chk("rr.done", 32'(done), 32'd1);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr.order%0d", i), (order.size() > i) ? 32'(order[i]) : 32'd99, 32'(exp_order[i]));
    tick();

    // Reset during the ACCESS cycle of a store aborts it
    issue(0, 1'b1, 32'h10, 32'hCAFEF00D);
    tick();
    chk("abt.wr", 32'(bus.mem_memWrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abt.strb", 32'({bus.mem_memWrite, bus.mem_memRead, busy}), 32'd0);
    chk("abt.ack",  32'({bus.ack0, bus.ack1}), 32'd0);
    chk("abt.addr", bus.mem_address, 32'd0);
    chk("abt.rd1",  bus.rdata1, 32'd0);
    drop(0);
    tick();
    tick();
    chk("abt.noack", 32'({bus.ack0, bus.ack1}), 32'd0);
    reset = 1'b1;
    tick();
    run_one("abt.ld", 0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 32'd4, 1'b1, 32'h1000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
